// File: rtl/main_mem_pkg.sv
// Shared definitions for the main-memory responder: FSM encoding and width helpers.
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_WAIT  = 2'd1,
        RD_WAIT  = 2'd2,
        RD_BURST = 2'd3
    } memState_e;

    localparam int DEFAULT_WORDS_PER_BLOCK = 4;
    localparam int DEFAULT_LATENCY         = 4;

    function automatic int offsetWidth(input int wordsPerBlock);
        return $clog2(wordsPerBlock);
    endfunction

    // The latency counter only has to reach (latency - 1), so log2 of the larger latency suffices.
    function automatic int latCntWidth(input int rdLatency, input int wrLatency);
        int maxLat;
        maxLat = (rdLatency > wrLatency) ? rdLatency : wrLatency;
        return (maxLat < 2) ? 1 : $clog2(maxLat);
    endfunction

    localparam int OFFSET_W  = offsetWidth(DEFAULT_WORDS_PER_BLOCK);
    localparam int LAT_CNT_W = latCntWidth(DEFAULT_LATENCY, DEFAULT_LATENCY);

endpackage

// File: rtl/main_mem_array.sv
// Word-addressed storage behind the responder: synchronous write, registered read port.
module main_mem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              re,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are deliberately not reset; only the read register sees a new value per beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wrAddr] <= wrData;
        end
        if (re) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/main_mem_responder.sv
// Latency-modelling main memory behind the write-through cache; serves word writes and block refills.
// Define MAIN_MEM_CRITICAL_WORD_FIRST_EN to start refill bursts at the requested word offset.
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
    parameter int RD_LATENCY      = DEFAULT_LATENCY,
    parameter int WR_LATENCY      = DEFAULT_LATENCY
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               rd_req,
    input  logic [ADDR_W-1:0]                  rd_addr,
    input  logic                               wr_req,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    output logic                               busy,
    output logic                               rd_valid,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] rd_word_idx,
    output logic [DATA_W-1:0]                  rd_data,
    output logic                               rd_last,
    output logic                               wr_done
);

    localparam int OffsetW  = offsetWidth(WORDS_PER_BLOCK);
    localparam int LatW     = latCntWidth(RD_LATENCY, WR_LATENCY);
    localparam int BeatCntW = OffsetW + 1;

    memState_e state, nextState;

    logic [LatW-1:0]     latCnt;
    logic [BeatCntW-1:0] beatCnt;
    logic [ADDR_W-1:0]   addrQ;
    logic [DATA_W-1:0]   wrDataQ;
    logic [OffsetW-1:0]  startOff;
    logic [OffsetW-1:0]  nextOff;
    logic [OffsetW-1:0]  rdIdxQ;
    logic [ADDR_W-1:0]   memRdAddr;
    logic [DATA_W-1:0]   memRdData;
    logic                acceptWr, acceptRd, latDone, burstDone, issueBeat, memWe;
    logic                rdValidQ, rdLastQ, wrDoneQ;

    assign latDone = ((state == WR_WAIT) && (latCnt == LatW'(WR_LATENCY - 1))) ||
                     ((state == RD_WAIT) && (latCnt == LatW'(RD_LATENCY - 1)));
    assign burstDone = (beatCnt == BeatCntW'(WORDS_PER_BLOCK));

`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    assign startOff = addrQ[OffsetW-1:0];
`else
    assign startOff = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Writes take priority over a simultaneous read; the held read is picked up on a later IDLE cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    nextState = WR_WAIT;
                end else if (rd_req) begin
                    nextState = RD_WAIT;
                end
            end
            WR_WAIT:  if (latDone)   nextState = IDLE;
            RD_WAIT:  if (latDone)   nextState = RD_BURST;
            RD_BURST: if (burstDone) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        acceptWr  = (state == IDLE) && wr_req;
        acceptRd  = (state == IDLE) && rd_req && !wr_req;
        memWe     = (state == WR_WAIT) && latDone;
        issueBeat = ((state == RD_WAIT) && latDone) || ((state == RD_BURST) && !burstDone);
        nextOff   = (state == RD_BURST) ? rdIdxQ + 1'b1 : startOff;
        memRdAddr = {addrQ[ADDR_W-1:OffsetW], nextOff};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latCnt  <= '0;
            beatCnt <= '0;
            addrQ   <= '0;
            wrDataQ <= '0;
        end else begin
            if (acceptWr) begin
                addrQ   <= wr_addr;
                wrDataQ <= wr_data;
            end else if (acceptRd) begin
                addrQ <= rd_addr;
            end
            if ((state == IDLE) || latDone) begin
                latCnt <= '0;
            end else if ((state == WR_WAIT) || (state == RD_WAIT)) begin
                latCnt <= latCnt + 1'b1;
            end
            if (state == IDLE) begin
                beatCnt <= '0;
            end else if (issueBeat) begin
                beatCnt <= beatCnt + 1'b1;
            end
        end
    end

    // Beat qualifiers are registered alongside the array read so they line up with rdData.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdValidQ <= 1'b0;
            rdLastQ  <= 1'b0;
            rdIdxQ   <= '0;
            wrDoneQ  <= 1'b0;
        end else begin
            wrDoneQ  <= memWe;
            rdValidQ <= issueBeat;
            if (issueBeat) begin
                rdIdxQ  <= nextOff;
                rdLastQ <= (beatCnt == BeatCntW'(WORDS_PER_BLOCK - 1));
            end else begin
                rdIdxQ  <= '0;
                rdLastQ <= 1'b0;
            end
        end
    end

    main_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) memArray (
        .clk    (clk),
        .we     (memWe),
        .wrAddr (addrQ),
        .wrData (wrDataQ),
        .re     (issueBeat),
        .rdAddr (memRdAddr),
        .rdData (memRdData)
    );

    assign rd_valid    = rdValidQ;
    assign rd_last     = rdLastQ;
    assign rd_word_idx = rdIdxQ;
    assign wr_done     = wrDoneQ;
    assign rd_data     = rdValidQ ? memRdData : '0;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed self-checking bench for main_mem_responder at default parameters.
module tb_main_mem_responder;

    localparam int RL  = 4;
    localparam int WL  = 4;
    localparam int WPB = 4;

    logic        clk;
    logic        reset;
    logic        rd_req;
    logic [9:0]  rd_addr;
    logic        wr_req;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        rd_valid;
    logic [1:0]  rd_word_idx;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        wr_done;

    int compareCount  = 0;
    int mismatchCount = 0;

    main_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .rd_valid    (rd_valid),
        .rd_word_idx (rd_word_idx),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .wr_done     (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitWriteDone(output int busyCycles, output bit seen);
        int guard;
        busyCycles = 0;
        seen       = 1'b0;
        guard      = 0;
        while (!seen && guard < 20) begin
            if (busy) busyCycles++;
            tick();
            guard++;
            if (wr_done) seen = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [9:0] addr, input logic [31:0] data);
        int  busyCycles;
        bit  seen;
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_req = 1'b0;
        waitWriteDone(busyCycles, seen);
        checkOutput("wr_done seen", 64'(seen), 64'd1);
        checkOutput("write busy cycles", 64'(busyCycles), 64'(WL));
        checkOutput("busy low at wr_done", 64'(busy), 64'd0);
        tick();
        checkOutput("wr_done single pulse", 64'(wr_done), 64'd0);
    endtask

    // Starts one cycle after acceptance and follows the burst until busy drops.
    task automatic collectBurst(input logic [3:0][31:0] expData, input logic [3:0][1:0] expIdx);
        int beat;
        for (int k = 1; k <= RL + WPB; k++) begin
            tick();
            if (k < RL) begin
                checkOutput("rd_valid during wait", 64'(rd_valid), 64'd0);
                checkOutput("busy during wait", 64'(busy), 64'd1);
            end else if (k < RL + WPB) begin
                beat = k - RL;
                checkOutput("beat valid", 64'(rd_valid), 64'd1);
                checkOutput("beat idx", 64'(rd_word_idx), 64'(expIdx[beat]));
                checkOutput("beat data", 64'(rd_data), 64'(expData[beat]));
                checkOutput("beat last", 64'(rd_last), 64'(beat == WPB - 1));
            end else begin
                checkOutput("busy after burst", 64'(busy), 64'd0);
                checkOutput("rd_valid after burst", 64'(rd_valid), 64'd0);
                checkOutput("rd_data after burst", 64'(rd_data), 64'd0);
            end
        end
    endtask

    task automatic readBlock(input logic [9:0] addr, input logic [3:0][31:0] expData,
                             input logic [3:0][1:0] expIdx);
        rd_req  = 1'b1;
        rd_addr = addr;
        tick();
        checkOutput("read accepted busy", 64'(busy), 64'd1);
        rd_req = 1'b0;
        collectBurst(expData, expIdx);
    endtask

    initial begin
        int busyCycles;
        bit seen;

        reset   = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 10'd8;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        tick();
        tick();
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset rd_last", 64'(rd_last), 64'd0);
        checkOutput("reset wr_done", 64'(wr_done), 64'd0);
        checkOutput("reset rd_data", 64'(rd_data), 64'd0);
        checkOutput("reset rd_word_idx", 64'(rd_word_idx), 64'd0);
        rd_req = 1'b0;
        reset  = 1'b1;
        tick();
        checkOutput("idle after reset", 64'(busy), 64'd0);

        applyStimulus(10'd0, 32'd100);
        applyStimulus(10'd2, 32'd102);
        applyStimulus(10'd3, 32'd103);
        applyStimulus(10'd1, 32'd5);
        readBlock(10'd0, {32'd103, 32'd102, 32'd5, 32'd100}, {2'd3, 2'd2, 2'd1, 2'd0});

        applyStimulus(10'd4, 32'd10);
        applyStimulus(10'd5, 32'd11);
        applyStimulus(10'd6, 32'd12);
        applyStimulus(10'd7, 32'd13);
        readBlock(10'd4, {32'd13, 32'd12, 32'd11, 32'd10}, {2'd3, 2'd2, 2'd1, 2'd0});
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
        readBlock(10'd6, {32'd11, 32'd10, 32'd13, 32'd12}, {2'd1, 2'd0, 2'd3, 2'd2});
`else
        readBlock(10'd6, {32'd13, 32'd12, 32'd11, 32'd10}, {2'd3, 2'd2, 2'd1, 2'd0});
`endif

        // Simultaneous requests: the write completes first, then the held read is served.
        rd_req  = 1'b1;
        rd_addr = 10'd1;
        wr_req  = 1'b1;
        wr_addr = 10'd3;
        wr_data = 32'd10;
        tick();
        wr_req = 1'b0;
        waitWriteDone(busyCycles, seen);
        checkOutput("simul wr_done seen", 64'(seen), 64'd1);
        checkOutput("simul write busy cycles", 64'(busyCycles), 64'(WL));
        checkOutput("simul no read beats yet", 64'(rd_valid), 64'd0);
        tick();
        checkOutput("simul read accepted", 64'(busy), 64'd1);
        checkOutput("simul wr_done cleared", 64'(wr_done), 64'd0);
        rd_req = 1'b0;
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
        collectBurst({32'd100, 32'd10, 32'd102, 32'd5}, {2'd0, 2'd3, 2'd2, 2'd1});
`else
        collectBurst({32'd10, 32'd102, 32'd5, 32'd100}, {2'd3, 2'd2, 2'd1, 2'd0});
`endif

        // Reset in the middle of a write must leave the array untouched.
        wr_req  = 1'b1;
        wr_addr = 10'd5;
        wr_data = 32'd99;
        tick();
        wr_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("mid-write reset busy", 64'(busy), 64'd0);
        tick();
        tick();
        tick();
        checkOutput("mid-write reset no wr_done", 64'(wr_done), 64'd0);
        reset = 1'b1;
        tick();

        // Reset during the second beat truncates the burst without rd_last.
        rd_req  = 1'b1;
        rd_addr = 10'd4;
        tick();
        rd_req = 1'b0;
        repeat (RL) tick();
        tick();
        checkOutput("second beat valid", 64'(rd_valid), 64'd1);
        checkOutput("second beat idx", 64'(rd_word_idx), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid-burst reset rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("mid-burst reset rd_data", 64'(rd_data), 64'd0);
        checkOutput("mid-burst reset rd_last", 64'(rd_last), 64'd0);
        checkOutput("mid-burst reset busy", 64'(busy), 64'd0);
        tick();
        tick();
        checkOutput("held reset rd_last", 64'(rd_last), 64'd0);
        reset = 1'b1;
        tick();
        readBlock(10'd4, {32'd13, 32'd12, 32'd11, 32'd10}, {2'd3, 2'd2, 2'd1, 2'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Main-memory model and responder sitting behind the write-through cache controller in Caching_system; it is the memory-side end of the controller's miss/write-through interface.
- Accepts single-word write-through requests and block-refill read requests.
- Applies a parameterised access latency, then returns a write completion pulse or streams the block one word per cycle.
- Replaces the zero-latency behavioural memory so stall behaviour is exercised with realistic timing.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2**ADDR_W words.
- DATA_W, 32, word width.
- WORDS_PER_BLOCK, 4, cache block size in words; power of two, >= 2.
- RD_LATENCY, 4, cycles from read acceptance to first beat; >= 1.
- WR_LATENCY, 4, cycles from write acceptance to completion; >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rd_req  input  1  block read request (level).
- rd_addr  input  ADDR_W  word address of the miss.
- wr_req  input  1  word write request (level).
- wr_addr  input  ADDR_W  write word address.
- wr_data  input  DATA_W  write data.
- busy  output  1  high whenever the FSM is not IDLE.
- rd_valid  output  1  read beat valid.
- rd_word_idx  output  log2(WORDS_PER_BLOCK)  block offset of the current beat.
- rd_data  output  DATA_W  beat data.
- rd_last  output  1  final beat of the burst.
- wr_done  output  1  one-cycle write completion pulse.

Behaviour:
- Reset (reset=0, async): FSM goes to IDLE; latency and beat counters clear; busy, rd_valid, rd_last, wr_done, rd_word_idx and rd_data are all 0. Array contents are NOT reset.
- FSM states:
  - IDLE: wait for a request.
  - WR_WAIT: count WR_LATENCY.
  - RD_WAIT: count RD_LATENCY.
  - RD_BURST: stream WORDS_PER_BLOCK beats.
- Requests are sampled only in IDLE; requests while busy are ignored, and the controller holds them until acceptance.
- Acceptance edge E0:
  - Capture the address (and data for a write).
  - For a read, the block base is rd_addr with the low offset bits cleared.
- Simultaneous rd_req and wr_req in IDLE: the write wins. A still-held read is accepted on the first IDLE edge after wr_done, so it returns post-write data.
- Write timing:
  - busy is high from E0 to E(WR_LATENCY).
  - The array is written at edge E(WR_LATENCY), when the FSM returns to IDLE.
  - wr_done is high for exactly the one cycle following that edge, during which a new request may be accepted.
- Read timing:
  - RD_WAIT lasts until E(RD_LATENCY).
  - rd_valid is high for the WORDS_PER_BLOCK consecutive cycles starting at E(RD_LATENCY).
  - rd_last is high with the final beat.
  - busy drops at E(RD_LATENCY+WORDS_PER_BLOCK).
  - Beat order is offsets 0,1,..,WORDS_PER_BLOCK-1; rd_word_idx equals the offset.
- Registered outputs:
  - rd_data is registered from the array.
  - rd_data is 0 when rd_valid is low.
- Address arithmetic: the offset counter wraps modulo WORDS_PER_BLOCK; the block base never changes during a burst.
- Reset mid-operation:
  - An in-flight write is aborted with the array unchanged.
  - An in-flight burst is truncated with no rd_last.

Optional Feature:
- MAIN_MEM_CRITICAL_WORD_FIRST_EN defined:
  - The burst starts at the rd_addr offset and wraps modulo WORDS_PER_BLOCK.
  - rd_word_idx reports the true offset of each beat.
  - rd_last is asserted on the WORDS_PER_BLOCK-th beat.
- Undefined: the rd_addr offset bits are ignored and the order is always 0..N-1.

Decomposition:
- Package main_mem_pkg holds:
  - the state encoding (IDLE, WR_WAIT, RD_WAIT, RD_BURST);
  - OFFSET_W = log2(WORDS_PER_BLOCK);
  - the latency counter width.
- Sub-module main_mem_array holds the storage: 2**ADDR_W x DATA_W, synchronous write, registered read port. The top level holds the FSM and counters.

Test Plan:
- Reset: hold reset=0 for 2 cycles with rd_req=1 -> busy, rd_valid, rd_last, wr_done and rd_data all 0; no acceptance.
- Write: wr_req, wr_addr=1, wr_data=5, defaults -> busy high 4 cycles; wr_done single pulse in the cycle after E4; a later read of block 0 returns 5 on the beat with rd_word_idx=1.
- Read: rd_req, rd_addr=4 after writes 10/11/12/13 to addresses 4..7 -> rd_valid cycles E4..E7 with data 10,11,12,13 and idx 0..3; rd_last only on 13; busy low at E8.
- Simultaneous: rd_req and wr_req held, wr_addr=3, wr_data=10, rd_addr=1 -> write completes first (wr_done); read then accepted; beat idx 3 = 10.
- Reset mid-burst: assert reset=0 during the 2nd beat -> rd_valid and rd_data drop to 0 immediately with no rd_last; after release, a new read of the same block returns the full correct burst.
- With MAIN_MEM_CRITICAL_WORD_FIRST_EN: rd_addr=6 -> rd_word_idx sequence 2,3,0,1 with matching data; rd_last on idx 1.
